// File: rtl/tcu_drl_norm_round_if.sv
// Handshake bus for tcu_drl_norm_round: accumulated-sum input beat and packed result beat.
interface tcu_drl_norm_round_if #(
    parameter int W     = 29,
    parameter int TAG_W = 8
);
    logic             valid_in;
    logic             ready_in;
    logic [W-1:0]     sig_in;
    logic [7:0]       exp_in;
    logic             fmt_sel;
    logic [TAG_W-1:0] tag_in;
    logic             valid_out;
    logic             ready_out;
    logic [31:0]      result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output valid_in, sig_in, exp_in, fmt_sel, tag_in, ready_out,
        input  ready_in, valid_out, result, tag_out
    );
    modport slave (
        input  valid_in, sig_in, exp_in, fmt_sel, tag_in, ready_out,
        output ready_in, valid_out, result, tag_out
    );
endinterface

// File: rtl/tcu_drl_norm_round.sv
// Decodes the DRL accumulator's wide fixed-point sum back into an FP32 word
// (normalize, RNE, pack) or passes it through as an integer; 3-stage pipeline.
module tcu_drl_norm_round #(
    parameter int N     = 5,
    parameter int W     = 25 + $clog2(N) + 1,
    parameter int TAG_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    tcu_drl_norm_round_if.slave bus
);
    localparam int STAGES = 3;
    localparam int LZ_W   = $clog2(W + 1);

    logic [STAGES:1] vld_pipe;
    logic            adv;

    // stage 1: sign / magnitude
    logic             s1_s, s1_fmt;
    logic [W-1:0]     s1_mag;
    logic [7:0]       s1_exp;
    logic [TAG_W-1:0] s1_tag;

    // stage 2: normalized fields
    logic               s2_s, s2_fmt, s2_zero, s2_g, s2_st;
    logic [22:0]        s2_mant;
    logic signed [9:0]  s2_e;
    logic [W-1:0]       s2_int;
    logic [TAG_W-1:0]   s2_tag;

    logic               neg_c;
    logic [W-1:0]       mag_c;
    logic [LZ_W-1:0]    lz;
    logic [W-1:0]       norm;
    logic signed [9:0]  e_c;
    logic               inc;
    logic [23:0]        mant_sum;
    logic signed [9:0]  e_r;
    logic [31:0]        res_c;

    assign adv          = !vld_pipe[STAGES] || bus.ready_out;
    assign bus.ready_in = adv;
    assign bus.valid_out = vld_pipe[STAGES];

    always_comb begin
        neg_c = !bus.fmt_sel && bus.sig_in[W-1];
        // W-bit negate maps -2^(W-1) onto 2^(W-1), which is the wanted magnitude
        mag_c = neg_c ? (W'(0) - bus.sig_in) : bus.sig_in;
    end

    always_comb begin
        lz = '0;
        for (int i = 0; i < W; i++) begin
            if (s1_mag[i]) lz = LZ_W'(W - 1 - i);
        end
        norm = s1_mag << lz;
        e_c  = $signed(10'(s1_exp) + 10'(W - 24) - 10'(lz));
    end

    always_comb begin
        inc      = s2_g && (s2_st || s2_mant[0]);
        mant_sum = {1'b0, s2_mant} + {23'd0, inc};
        e_r      = s2_e + $signed({9'd0, mant_sum[23]});
        if (s2_fmt)               res_c = 32'(s2_int);
        else if (s2_zero)         res_c = 32'd0;
        else if (e_r >= 10'sd255) res_c = {s2_s, 8'hFF, 23'd0};
        else if (e_r <= 10'sd0)   res_c = {s2_s, 31'd0};
        else                      res_c = {s2_s, e_r[7:0], mant_sum[22:0]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe    <= '0;
            bus.result  <= '0;
            bus.tag_out <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.valid_in};

            s1_s   <= neg_c;
            s1_fmt <= bus.fmt_sel;
            s1_mag <= mag_c;
            s1_exp <= bus.exp_in;
            s1_tag <= bus.tag_in;

            s2_s    <= s1_s;
            s2_fmt  <= s1_fmt;
            s2_zero <= (s1_mag == '0);
            s2_mant <= norm[W-2 -: 23];
            s2_g    <= norm[W-25];
            s2_st   <= |norm[W-26:0];
            s2_e    <= e_c;
            s2_int  <= s1_mag;
            s2_tag  <= s1_tag;

            bus.result  <= res_c;
            bus.tag_out <= s2_tag;
        end
    end
endmodule

// File: tb/tb_tcu_drl_norm_round.sv
// Bench for tcu_drl_norm_round: directed vectors plus randomized streams against a
// real-arithmetic FP32 reference model.
module tb_tcu_drl_norm_round;
    localparam int N     = 5;
    localparam int W     = 25 + $clog2(N) + 1;
    localparam int TAG_W = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_fail = 0;

    tcu_drl_norm_round_if #(.W(W), .TAG_W(TAG_W)) bus ();

    tcu_drl_norm_round #(.N(N), .W(W), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Value = signed sum * 2^(exp-150); rounded from an exact double to FP32 RNE,
    // then overflow to inf and underflow flushed to signed zero.
    function automatic logic [31:0] model(input logic [W-1:0] sig, input logic [7:0] ex,
                                          input logic fmt);
        real         v;
        logic [63:0] d;
        int          e;
        logic [22:0] keep;
        logic [28:0] rem;
        longint      m;
        logic        neg;
        if (fmt) return 32'(sig);
        neg = sig[W-1];
        m = neg ? ((longint'(1) << W) - longint'(sig)) : longint'(sig);
        if (m == 0) return 32'd0;
        v = real'(m);
        for (int i = 0; i < int'(ex); i++) v = v * 2.0;
        for (int i = 0; i < 150; i++) v = v / 2.0;
        d    = $realtobits(v);
        e    = int'(d[62:52]) - 1023 + 127;
        keep = d[51:29];
        rem  = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) begin
            if (keep == '1) begin
                keep = '0;
                e++;
            end else begin
                keep = keep + 23'd1;
            end
        end
        if (e >= 255) return {neg, 8'hFF, 23'd0};
        if (e <= 0) return {neg, 31'd0};
        return {neg, e[7:0], keep};
    endfunction

    task automatic idle_inputs();
        bus.valid_in  = 1'b0;
        bus.sig_in    = '0;
        bus.exp_in    = 8'd0;
        bus.fmt_sel   = 1'b0;
        bus.tag_in    = '0;
        bus.ready_out = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_chk++;
        if (bus.valid_out !== 1'b0 || bus.result !== 32'd0 || bus.tag_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid_out=%b result=%h tag=%h, want 0/0/0",
                     bus.valid_out, bus.result, bus.tag_out);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (bus.ready_in !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_in: got %b want 1", bus.ready_in);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] sigs [13];
        logic [7:0]   exps [13];
        logic         fmts [13];
        logic [31:0]  want [13];
        int           edges;
        sigs[0]  = W'(1) << 23;        exps[0]  = 8'd127; fmts[0]  = 0; want[0]  = 32'h3F80_0000;
        sigs[1]  = W'(0) - (W'(3) << 22); exps[1] = 8'd128; fmts[1] = 0; want[1]  = 32'hC040_0000;
        sigs[2]  = (W'(1) << 25) + 1;  exps[2]  = 8'd127; fmts[2]  = 0; want[2]  = 32'h4080_0000;
        sigs[3]  = (W'(1) << 25) + 2;  exps[3]  = 8'd127; fmts[3]  = 0; want[3]  = 32'h4080_0000;
        sigs[4]  = (W'(1) << 25) + 6;  exps[4]  = 8'd127; fmts[4]  = 0; want[4]  = 32'h4080_0002;
        sigs[5]  = W'(1) << 27;        exps[5]  = 8'd254; fmts[5]  = 0; want[5]  = 32'h7F80_0000;
        sigs[6]  = W'(1);              exps[6]  = 8'd10;  fmts[6]  = 0; want[6]  = 32'h0000_0000;
        sigs[7]  = W'(0);              exps[7]  = 8'd127; fmts[7]  = 0; want[7]  = 32'h0000_0000;
        sigs[8]  = W'(1) << (W - 1);   exps[8]  = 8'd127; fmts[8]  = 0;
        want[8]  = {1'b1, 8'(103 + W), 23'd0};
        sigs[9]  = W'(32'h0123_4567);  exps[9]  = 8'hA5;  fmts[9]  = 1; want[9]  = 32'h0123_4567;
        sigs[10] = W'(0) - (W'(1) << 27); exps[10] = 8'd254; fmts[10] = 0; want[10] = 32'hFF80_0000;
        sigs[11] = (W'(1) << 25) - 1;  exps[11] = 8'd127; fmts[11] = 0; want[11] = 32'h4080_0000;
        sigs[12] = W'(1) << (W - 1);   exps[12] = 8'd3;   fmts[12] = 1;
        want[12] = 32'(W'(1) << (W - 1));
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.valid_in  = 1'b1;
            bus.sig_in    = sigs[i];
            bus.exp_in    = exps[i];
            bus.fmt_sel   = fmts[i];
            bus.tag_in    = TAG_W'(8'h10 + i);
            bus.ready_out = 1'b1;
            #1;
            n_chk++;
            if (bus.ready_in !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_%0d_ready_in: got %b want 1", i, bus.ready_in);
            end
            edges = 0;
            do begin
                @(posedge clk);
                #1;
                edges++;
                bus.valid_in = 1'b0;
            end while (!bus.valid_out && edges < 10);
            n_chk++;
            if (edges !== 3) begin
                n_fail++;
                $display("FAIL directed_%0d_latency: got %0d edges want 3", i, edges);
            end
            n_chk++;
            if (bus.result !== want[i] || bus.tag_out !== TAG_W'(8'h10 + i)) begin
                n_fail++;
                $display("FAIL directed_%0d_result: got %h tag %h want %h tag %h", i,
                         bus.result, bus.tag_out, want[i], TAG_W'(8'h10 + i));
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // mode 0: back-to-back, no stall; 1: random valid/ready; 2: 4-cycle output stall mid-stream
    task automatic run_stream(input string name, input int nbeats, input int mode);
        logic [31:0]      exp_r [$];
        logic [TAG_W-1:0] exp_t [$];
        logic [31:0]      r, held_r;
        logic [TAG_W-1:0] t, held_t;
        logic             stalled;
        int               sent, got, cyc;
        sent = 0; got = 0; cyc = 0; stalled = 0;
        held_r = '0; held_t = '0;
        while ((sent < nbeats || got < nbeats) && cyc < 4000) begin
            @(negedge clk);
            if (stalled) begin
                n_chk++;
                if (bus.valid_out !== 1'b1 || bus.result !== held_r || bus.tag_out !== held_t) begin
                    n_fail++;
                    $display("FAIL %s_hold: valid %b result %h tag %h want 1 %h %h", name,
                             bus.valid_out, bus.result, bus.tag_out, held_r, held_t);
                end
            end
            if (sent < nbeats && (mode != 1 || $urandom_range(3) != 0)) begin
                bus.valid_in = 1'b1;
                bus.sig_in   = W'($urandom) >> $urandom_range(W - 1, 0);
                if ($urandom_range(1) == 1) bus.sig_in = W'(0) - bus.sig_in;
                bus.exp_in   = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 8)) :
                               ($urandom_range(3) == 0) ? 8'($urandom_range(240, 254)) :
                               8'($urandom_range(1, 254));
                bus.fmt_sel  = ($urandom_range(3) == 0);
                bus.tag_in   = TAG_W'(sent);
            end else begin
                bus.valid_in = 1'b0;
            end
            if (mode == 1)      bus.ready_out = ($urandom_range(2) != 0);
            else if (mode == 2) bus.ready_out = !(cyc >= 3 && cyc < 7);
            else                bus.ready_out = 1'b1;
            #1;
            n_chk++;
            if (bus.ready_in !== (!bus.valid_out || bus.ready_out)) begin
                n_fail++;
                $display("FAIL %s_ready_in: got %b with valid_out %b ready_out %b", name,
                         bus.ready_in, bus.valid_out, bus.ready_out);
            end
            if (bus.valid_out && bus.ready_out) begin
                n_chk++;
                if (exp_r.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra_beat: got %h tag %h, want no beat", name,
                             bus.result, bus.tag_out);
                end else begin
                    r = exp_r.pop_front();
                    t = exp_t.pop_front();
                    if (bus.result !== r || bus.tag_out !== t) begin
                        n_fail++;
                        $display("FAIL %s_beat_%0d: got %h tag %h want %h tag %h", name, got,
                                 bus.result, bus.tag_out, r, t);
                    end
                end
                got++;
            end
            if (bus.valid_in && bus.ready_in) begin
                exp_r.push_back(model(bus.sig_in, bus.exp_in, bus.fmt_sel));
                exp_t.push_back(bus.tag_in);
                sent++;
            end
            stalled = bus.valid_out && !bus.ready_out;
            held_r  = bus.result;
            held_t  = bus.tag_out;
            cyc++;
        end
        n_chk++;
        if (got != nbeats || sent != nbeats) begin
            n_fail++;
            $display("FAIL %s_count: sent %0d received %0d want %0d each", name, sent, got, nbeats);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        run_stream("random", 300, 1);
    endtask

    task automatic test_back_to_back();
        run_stream("back_to_back", 60, 0);
    endtask

    task automatic test_backpressure();
        run_stream("backpressure", 5, 2);
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        bus.ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.valid_in = 1'b1;
            bus.sig_in   = W'(1) << 23;
            bus.exp_in   = 8'd127;
            bus.fmt_sel  = 1'b0;
            bus.tag_in   = TAG_W'(8'hE0 + i);
            @(negedge clk);
        end
        bus.valid_in = 1'b0;
        n_chk++;
        if (bus.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_fill: valid_out %b want 1", bus.valid_out);
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if (bus.valid_out !== 1'b0 || bus.result !== 32'd0 || bus.tag_out !== '0) begin
            n_fail++;
            $display("FAIL inflight_reset: valid %b result %h tag %h want 0 0 0",
                     bus.valid_out, bus.result, bus.tag_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus.ready_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1) begin
                n_fail++;
                $display("FAIL inflight_stale_%0d: valid_out %b ready_in %b want 0 1", i,
                         bus.valid_out, bus.ready_in);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
